// File: rtl/fos_out_fifo.sv
// fos_out_fifo: rounds and rescales Q10 filter samples to 16 bits into a FWFT FIFO.
// Define FOS_OUT_SAT_EN to saturate out-of-range samples instead of wrapping.
module fos_out_fifo #(
  parameter int DEPTH = 16,
  parameter int SHIFT = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              y_in,
  input  logic                     in_valid,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output logic                     sat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);
  logic signed [32:0] sum, conv;
  logic [15:0] word, s1_data;
  logic s1_valid, pop, full, wr, ovf_set;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0] mem [DEPTH];
  logic unused_conv;
  assign sum = $signed({y_in[31], y_in}) + HALF;
  assign conv = sum >>> SHIFT;
  assign unused_conv = ^conv;
`ifdef FOS_OUT_SAT_EN
  logic sat_hi, sat_lo;
  assign sat_hi = conv > 33'sd32767;
  assign sat_lo = conv < -33'sd32768;
  assign word = sat_hi ? 16'h7fff : sat_lo ? 16'h8000 : conv[15:0];
  always_ff @(posedge clk)
    sat <= reset ? 1'b0 : (in_valid & (sat_hi | sat_lo)) ? 1'b1 : clear_ovf ? 1'b0 : sat;
`else
  assign word = conv[15:0];
  assign sat = 1'b0;
`endif
  assign out_valid = count != '0;
  assign out_data = out_valid ? mem[rd_ptr] : 16'h0000;
  assign pop = out_valid & out_ready;
  assign full = count == (AW + 1)'(DEPTH);
  // A pop frees the slot, so a write into a full FIFO succeeds on the same edge.
  assign wr = s1_valid & (~full | pop);
  assign ovf_set = s1_valid & full & ~pop;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      s1_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (wr & ~pop) ? count + (AW + 1)'(1) : (pop & ~wr) ? count - (AW + 1)'(1) : count;
      overflow <= ovf_set ? 1'b1 : clear_ovf ? 1'b0 : overflow;
    end
  end
  always_ff @(posedge clk) begin
    s1_data <= word;
    if (wr) mem[wr_ptr] <= s1_data;
  end
endmodule

// File: doc/fos_out_fifo.md
FOS_OUT_FIFO -- requirements
Module: fos_out_fifo

Interface
REQ-001 Parameter DEPTH, 16, FIFO depth in words; power of two, 4..64.
REQ-002 Parameter SHIFT, 10, arithmetic right shift applied to the Q10 filter output; 1..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 y_in  input  32  signed filter output sample, taken from the first-order-section y_out.
REQ-006 in_valid  input  1  y_in carries a new sample this cycle.
REQ-007 out_data  output  16  signed rescaled sample at the FIFO head.
REQ-008 out_valid  output  1  out_data holds a valid sample.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 count  output  clog2(DEPTH)+1  number of words stored.
REQ-011 overflow  output  1  sticky flag: a sample was dropped while the FIFO was full.
REQ-012 clear_ovf  input  1  clears overflow.
REQ-013 sat  output  1  sticky flag: a sample was saturated.

Function
REQ-014 Stage 1 SHALL register conv(y_in) and in_valid on each clk edge.
- conv = (y_in + 2^(SHIFT-1)) >>> SHIFT, computed at 33 bits (round half up).
- conv is then reduced to 16 bits according to REQ-030/031.
REQ-015 Stage 2 SHALL write the stage-1 word into the FIFO on the next edge when stage-1 valid is high.
REQ-016 The FIFO SHALL be first-word-fall-through:
- out_valid = (count != 0);
- out_data = head word when out_valid is high, 0x0000 otherwise.
REQ-017 Latency: in_valid high at edge k with the FIFO empty -> out_valid high and out_data correct after edge k+1.
REQ-018 A pop SHALL occur at an edge where out_valid and out_ready are both high.
- out_ready while the FIFO is empty has no effect.
REQ-019 Ordering SHALL be strictly first in, first out.
- Read and write pointers wrap modulo DEPTH.
REQ-020 Write while full with no pop at the same edge:
- the word is dropped;
- overflow is set at that edge;
- count and contents are unchanged.
REQ-021 Write and pop at the same edge SHALL both take effect at any fill level, including full.
- count is unchanged.
- overflow is not set.
REQ-022 count SHALL change by +1 on a write only, -1 on a pop only, and 0 on both or neither.
REQ-023 When clear_ovf coincides with a new overflow event, the set SHALL win.
REQ-024 clear_ovf SHALL also clear sat, with the same set-wins rule.
REQ-025 A continuous in_valid stream SHALL be accepted at one sample per clock.
- There are no bubbles or stalls on the input side.
- The block has no backpressure to the filter.

Reset
REQ-026 While reset is high at an edge, the following SHALL all be 0 after that edge: pointers, count, stage-1 valid, overflow, sat.
- Consequently out_valid = 0 and out_data = 0x0000.
REQ-027 Reset mid-operation SHALL discard all stored words and any in-flight stage-1 sample.
REQ-028 FIFO storage SHALL NOT be reset.
REQ-029 in_valid, out_ready and clear_ovf SHALL be ignored during reset.

Configuration
REQ-030 With FOS_OUT_SAT_EN defined:
- conv values above 32767 SHALL become 0x7FFF;
- conv values below -32768 SHALL become 0x8000;
- sat is set when such a sample is written into stage 1.
REQ-031 Without FOS_OUT_SAT_EN:
- conv SHALL be truncated to its low 16 bits (wrap);
- sat SHALL be tied to 0;
- no saturation logic is synthesised.

Verification
REQ-032 Basic path: reset, then y_in=0x00000400 with in_valid for 1 cycle -> out_data=0x0001 and out_valid=1 after edge k+1; count=1.
REQ-033 Rounding, one sample each:
- y_in=0x00000200 -> 0x0001;
- y_in=0x000001FF -> 0x0000;
- y_in=0xFFFFFE00 -> 0x0000;
- y_in=0xFFFFFBFF -> 0xFFFF.
REQ-034 Limits:
- y_in=0x7FFFFFFF -> 0x7FFF with sat=1 under FOS_OUT_SAT_EN, 0x0000 with sat=0 without;
- y_in=0x80000000 -> 0x8000 with the macro, 0x0000 without.
REQ-035 Fill and drain: out_ready=0, 17 consecutive samples 1..17 (scaled by 1024).
- Expect count=16 and overflow=1 after the 17th write.
- With out_ready=1, the drain yields 1..16 in order, then out_valid=0.
REQ-036 Full with a simultaneous write and pop (FIFO full, out_ready=1, in_valid stream):
- count stays 16 and overflow stays 0;
- clear_ovf together with an overflow event leaves overflow=1.
REQ-037 Reset mid-operation: count=5 plus one sample in stage 1, reset for 1 cycle.
- Expect count=0, out_valid=0 and overflow=0.
- The in-flight sample never appears.
